multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared MIPS-subset datapath over multiple cycles. It replaces the single-cycle combinational controller.
- One unified memory serves both instruction fetch and data access, selected by iord.
- Inputs are the decoded op/funct fields, taken from the instruction register, and the ALU zero flag.
- Outputs drive every datapath mux select and write enable, one instruction step per state.

Parameters:
- MEM_WAIT_CYCLES, 0: extra wait cycles inserted in each memory-access state (FETCH, MEMREAD, MEMWRITE). Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instr[31:26], held stable from the IR after FETCH.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out register.
- ir_write  out  1  instruction register load.
- pc_en  out  1  PC load.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALU out register, 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_ctrl_sig  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- reg_dst  out  1  register write address: 1 = rd, 0 = rt.
- mem_to_reg  out  1  register write data: 1 = memory data, 0 = ALU out.
- reg_write  out  1  register file write enable.
- write_enab  out  1  data memory write enable.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset:
  - reset sampled high → state=FETCH and wait counter=0 on the next edge.
  - While reset is high, all enables (ir_write, pc_en, reg_write, write_enab, instr_done) are forced to 0.
  - Reset mid-instruction aborts it with no further writes.
- Outputs are decoded combinationally from state (and from the wait counter and zero where noted). Any output not listed for a state is 0.
- Wait counter (memory states only):
  - Counts 0..MEM_WAIT_CYCLES while in a memory state.
  - The state advances only when count==MEM_WAIT_CYCLES.
  - The counter clears on every state change.
  - With MEM_WAIT_CYCLES=0, each memory state lasts 1 cycle.
- FETCH:
  - Every cycle: iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010.
  - Final wait cycle only: ir_write=1, pc_en=1 (pc_src=00).
  - Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010. Next state by op:
  - 100011 or 101011 → MEMADR.
  - 000000 → EXECUTE.
  - 000100 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - Any other op → FETCH with instr_done=1 (illegal opcode is a no-op).
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=010. Next: op 100011 → MEMREAD, else MEMWRITE.
- MEMREAD: iord=1 every cycle. Next: MEMWB after the final wait cycle.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
- MEMWRITE:
  - iord=1 every cycle.
  - Final wait cycle only: write_enab=1, instr_done=1.
  - Next: FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00. alu_ctrl by funct:
  - 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001; 101010 → 111; next state ALUWB.
  - Any other funct → alu_ctrl=010, next state FETCH with instr_done=1 and no register write.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, pc_en=zero, instr_done=1. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=010. Next: ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Next: FETCH.
- Unused encodings 12..15 → FETCH on the next edge, with all enables 0.
- Latency with MEM_WAIT_CYCLES=W: lw 5+2W, sw 4+2W, R-type 4+W, addi 4+W, beq 3+W, j 3+W cycles.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN.
- Defined: op 000101 (bne) in DECODE → BRANCH. BRANCH then drives pc_en = ~zero for bne and pc_en = zero for beq.
- Undefined: op 000101 is an illegal opcode, so DECODE → FETCH with no writes.

Test Plan:
- Reset held 3 cycles mid-MEMREAD, then released → state_o=0, all enables 0 during reset; ir_write=1 and pc_en=1 on the first cycle after release.
- W=0, op=100011 → state_o sequence 0,1,2,3,4; reg_write=1 with mem_to_reg=1 only in state 4; instr_done pulses exactly once.
- W=2, op=101011 → FETCH lasts 3 cycles (ir_write only on the 3rd); MEMWRITE lasts 3 cycles with write_enab=1 only on the 3rd; total 8 cycles.
- op=000000, funct=100010 → EXECUTE alu_ctrl=110, ALUWB reg_dst=1; funct=111111 → no reg_write, back to FETCH after 3 cycles.
- op=000100 with zero=1 → pc_en=1, pc_src=01 in BRANCH; zero=0 → pc_en=0.
- op=000101, zero=0: with the macro → BRANCH, pc_en=1; without the macro → DECODE→FETCH, no enables asserted.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the shared MIPS-subset datapath
// (slave): decoded instruction fields and zero flag in, mux selects and write enables out.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl_sig;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       write_enab;
  logic       instr_done;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero,
    output iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctrl_sig,
           reg_dst, mem_to_reg, reg_write, write_enab, instr_done, state_o
  );

  modport slave (
    output op, funct, zero,
    input  iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctrl_sig,
           reg_dst, mem_to_reg, reg_write, write_enab, instr_done, state_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS-subset datapath, with optional memory wait states.
// Define MULTICYCLE_CTRL_BNE_EN to add bne (op 000101) through the BRANCH state.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_CYCLES = 0
) (
  input logic                          clk,
  input logic                          reset,
  multicycle_controller_if.master      bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif
  localparam logic [3:0] WaitLast = 4'(MEM_WAIT_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_mem, wait_done, funct_ok;
  logic [2:0] r_alu;

  assign is_mem    = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign wait_done = (cnt_q == WaitLast);
  // Counter only runs inside memory states and restarts on every state change.
  assign cnt_d     = (is_mem && !wait_done) ? cnt_q + 4'd1 : 4'd0;

  always_comb begin
    funct_ok = 1'b1;
    r_alu    = 3'b010;
    case (bus.funct)
      6'b100000: r_alu = 3'b010;
      6'b100010: r_alu = 3'b110;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b101010: r_alu = 3'b111;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (wait_done) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (wait_done) state_d = StMemWb;
      StMemWrite: if (wait_done) state_d = StFetch;
      StExecute:  state_d = funct_ok ? StAluWb : StFetch;
      StAddiEx:   state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.iord         = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_en        = 1'b0;
    bus.pc_src       = 2'b00;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 2'b00;
    bus.alu_ctrl_sig = 3'b000;
    bus.reg_dst      = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.reg_write    = 1'b0;
    bus.write_enab   = 1'b0;
    bus.instr_done   = 1'b0;
    case (state_q)
      StFetch: begin
        bus.alu_src_b    = 2'b01;
        bus.alu_ctrl_sig = 3'b010;
        bus.ir_write     = wait_done;
        bus.pc_en        = wait_done;
      end
      StDecode: begin
        bus.alu_src_b    = 2'b11;
        bus.alu_ctrl_sig = 3'b010;
        bus.instr_done   = (state_d == StFetch);
      end
      StMemAdr, StAddiEx: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = 2'b10;
        bus.alu_ctrl_sig = 3'b010;
      end
      StMemRead: bus.iord = 1'b1;
      StMemWb: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      StMemWrite: begin
        bus.iord       = 1'b1;
        bus.write_enab = wait_done;
        bus.instr_done = wait_done;
      end
      StExecute: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_ctrl_sig = r_alu;
        bus.instr_done   = !funct_ok;
      end
      StAluWb: begin
        bus.reg_dst    = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      StBranch: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_ctrl_sig = 3'b110;
        bus.pc_src       = 2'b01;
`ifdef MULTICYCLE_CTRL_BNE_EN
        bus.pc_en        = (bus.op == OpBne) ? !bus.zero : bus.zero;
`else
        bus.pc_en        = bus.zero;
`endif
        bus.instr_done   = 1'b1;
      end
      StAddiWb: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      StJump: begin
        bus.pc_src     = 2'b10;
        bus.pc_en      = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every write so an aborted instruction leaves no side effects.
    if (reset) begin
      bus.ir_write   = 1'b0;
      bus.pc_en      = 1'b0;
      bus.reg_write  = 1'b0;
      bus.write_enab = 1'b0;
      bus.instr_done = 1'b0;
    end
  end

  assign bus.state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: two controllers (0 and 2 memory wait cycles) run random instruction streams;
// a per-instruction model queues the expected cycle-by-cycle outputs, a monitor pops and compares.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       write_enab;
    logic       instr_done;
  } vec_t;

  localparam int NumInst = 2;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [NumInst];
  logic [5:0] op_v    [NumInst];
  logic [5:0] funct_v [NumInst];
  logic       zero_v  [NumInst];
  vec_t       got_v   [NumInst];
  vec_t       exp_q   [NumInst][$];
  int         total = 0;
  int         bad   = 0;

  for (genvar g = 0; g < NumInst; g++) begin : g_dut
    multicycle_controller_if bus ();
    assign bus.op    = op_v[g];
    assign bus.funct = funct_v[g];
    assign bus.zero  = zero_v[g];
    assign got_v[g]  = {bus.state_o, bus.iord, bus.ir_write, bus.pc_en, bus.pc_src,
                        bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl_sig, bus.reg_dst,
                        bus.mem_to_reg, bus.reg_write, bus.write_enab, bus.instr_done};
    multicycle_controller #(.MEM_WAIT_CYCLES(2 * g)) u_dut (
      .clk   (clk),
      .reset (rst_v[g]),
      .bus   (bus.master)
    );
  end

  function automatic vec_t mk(int st);
    vec_t v;
    v    = '0;
    v.st = 4'(st);
    return v;
  endfunction

  // Fetch-step output with the write enables stripped, as seen while reset is held.
  function automatic vec_t fetch_rst();
    vec_t v;
    v           = mk(0);
    v.alu_src_b = 2'b01;
    v.alu_ctrl  = 3'b010;
    return v;
  endfunction

  // {legal, alu op} for an R-type funct field.
  function automatic logic [3:0] r_dec(logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected per-cycle trace of one instruction; only the first 'upto' cycles are queued.
  task automatic model(int g, int w, logic [5:0] op, logic [5:0] f, logic z, int upto);
    vec_t       tr[$];
    vec_t       v;
    logic [3:0] rd;
    bit is_lw, is_sw, is_r, is_br, is_addi, is_j;
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_r    = (op == 6'b000000);
    is_br   = (op == 6'b000100) || (BneEn && op == 6'b000101);
    is_addi = (op == 6'b001000);
    is_j    = (op == 6'b000010);
    for (int i = 0; i <= w; i++) begin
      v = fetch_rst();
      if (i == w) begin
        v.ir_write = 1'b1;
        v.pc_en    = 1'b1;
      end
      tr.push_back(v);
    end
    v = mk(1);
    v.alu_src_b = 2'b11;
    v.alu_ctrl  = 3'b010;
    v.instr_done = !(is_lw || is_sw || is_r || is_br || is_addi || is_j);
    tr.push_back(v);
    if (is_lw || is_sw) begin
      v = mk(2); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_ctrl = 3'b010;
      tr.push_back(v);
      for (int i = 0; i <= w; i++) begin
        v = mk(is_lw ? 3 : 5);
        v.iord = 1'b1;
        if (is_sw && i == w) begin
          v.write_enab = 1'b1;
          v.instr_done = 1'b1;
        end
        tr.push_back(v);
      end
      if (is_lw) begin
        v = mk(4); v.mem_to_reg = 1'b1; v.reg_write = 1'b1; v.instr_done = 1'b1;
        tr.push_back(v);
      end
    end else if (is_r) begin
      rd = r_dec(f);
      v = mk(6); v.alu_src_a = 1'b1; v.alu_ctrl = rd[2:0]; v.instr_done = !rd[3];
      tr.push_back(v);
      if (rd[3]) begin
        v = mk(7); v.reg_dst = 1'b1; v.reg_write = 1'b1; v.instr_done = 1'b1;
        tr.push_back(v);
      end
    end else if (is_br) begin
      v = mk(8); v.alu_src_a = 1'b1; v.alu_ctrl = 3'b110; v.pc_src = 2'b01;
      v.pc_en = (op == 6'b000101) ? !z : z;
      v.instr_done = 1'b1;
      tr.push_back(v);
    end else if (is_addi) begin
      v = mk(9); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_ctrl = 3'b010;
      tr.push_back(v);
      v = mk(10); v.reg_write = 1'b1; v.instr_done = 1'b1;
      tr.push_back(v);
    end else if (is_j) begin
      v = mk(11); v.pc_src = 2'b10; v.pc_en = 1'b1; v.instr_done = 1'b1;
      tr.push_back(v);
    end
    for (int i = 0; i < tr.size() && i < upto; i++) exp_q[g].push_back(tr[i]);
  endtask

  task automatic wait_empty(int g);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (exp_q[g].size() != 0 && n < 100);
    if (exp_q[g].size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain inst%0d: pending=%0d required=0", g, exp_q[g].size());
      exp_q[g].delete();
    end
  endtask

  task automatic issue(int g, logic [5:0] op, logic [5:0] f, logic z, int upto);
    op_v[g]    = op;
    funct_v[g] = f;
    zero_v[g]  = z;
    model(g, 2 * g, op, f, z, upto);
    wait_empty(g);
  endtask

  task automatic run(int g);
    logic [5:0] ops   [8];
    logic [5:0] functs[6];
    vec_t       v;
    int         w;
    w = 2 * g;
    ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
               6'b000010, 6'b111111};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    rst_v[g]   = 1'b1;
    op_v[g]    = '0;
    funct_v[g] = '0;
    zero_v[g]  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q[g].push_back(fetch_rst());
    wait_empty(g);
    rst_v[g] = 1'b0;
    issue(g, 6'b100011, 6'b000000, 1'b0, 99);
    issue(g, 6'b101011, 6'b000000, 1'b0, 99);
    issue(g, 6'b000000, 6'b100010, 1'b0, 99);
    issue(g, 6'b000000, 6'b111111, 1'b0, 99);
    issue(g, 6'b000100, 6'b000000, 1'b1, 99);
    issue(g, 6'b000100, 6'b000000, 1'b0, 99);
    issue(g, 6'b000101, 6'b000000, 1'b0, 99);
    issue(g, 6'b001000, 6'b000000, 1'b0, 99);
    issue(g, 6'b000010, 6'b000000, 1'b0, 99);
    // lw cut off on entry to MEMREAD, then reset held for three cycles.
    issue(g, 6'b100011, 6'b000000, 1'b0, w + 3);
    rst_v[g] = 1'b1;
    v = mk(3);
    v.iord = 1'b1;
    exp_q[g].push_back(v);
    exp_q[g].push_back(fetch_rst());
    exp_q[g].push_back(fetch_rst());
    wait_empty(g);
    rst_v[g] = 1'b0;
    issue(g, 6'b001000, 6'b000000, 1'b0, 99);
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      logic [5:0] f;
      op = ops[$urandom_range(0, 7)];
      if (op == 6'b111111) op = 6'($urandom_range(0, 63));
      f = functs[$urandom_range(0, 5)];
      if (f == 6'b111111) f = 6'($urandom_range(0, 63));
      issue(g, op, f, 1'($urandom_range(0, 1)), 99);
    end
  endtask

  always @(negedge clk) begin
    vec_t e;
    for (int g = 0; g < NumInst; g++) begin
      if (exp_q[g].size() > 0) begin
        e = exp_q[g].pop_front();
        total++;
        if (got_v[g] !== e) begin
          bad++;
          $display("FAIL cycle inst%0d t=%0t: got=%h required=%h", g, $time, got_v[g], e);
        end
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      run(0);
      run(1);
    join
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
